// File: rtl/adc_multi_capture.sv
// adc_multi_capture: lock-step N-channel serial ADC capture into a sample buffer.
// Ports: start/stop/mode/trig_en/trig/n_samples/ch_mask control, sdo in,
//        cs_n/sclk to ADCs, buf_we/buf_addr/buf_din write port, busy/done/
//        wrapped/sample_cnt status.
module adc_multi_capture #(
    parameter int NCH    = 2,
    parameter int DW     = 12,
    parameter int FRAME  = 16,
    parameter int CLKDIV = 4,
    parameter int AW     = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           stop,
    input  logic           mode,
    input  logic           trig_en,
    input  logic           trig,
    input  logic [AW-1:0]  n_samples,
    input  logic [NCH-1:0] ch_mask,
    input  logic [NCH-1:0] sdo,
    output logic [NCH-1:0] cs_n,
    output logic [NCH-1:0] sclk,
    output logic           buf_we,
    output logic [AW-1:0]  buf_addr,
    output logic [DW-1:0]  buf_din,
    output logic           busy,
    output logic           done,
    output logic           wrapped,
    output logic [AW-1:0]  sample_cnt
);

    localparam int DCW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BCW = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        IDLE, WAIT_TRIG, CONV, QUIET, STORE, CHECK
    } state_t;

    state_t state_q, state_d;

    logic                    mode_q;
    logic                    trig_en_q;
    logic                    stop_q;
    logic [AW-1:0]           n_q;
    logic [NCH-1:0]          mask_q;
    logic [DCW-1:0]          div_cnt;
    logic [BCW-1:0]          bit_cnt;
    logic                    hi;
    logic [CW-1:0]           ch_idx;
    logic [AW-1:0]           wr_ptr;
    logic [NCH-1:0][DW-1:0]  sh;

    logic          div_wrap;
    logic          bit_last;
    logic          go;
    logic          fin;
    logic          zero_shot;
    logic [CW-1:0] first_ch;
    logic [CW-1:0] nxt_ch;
    logic          has_nxt;
    logic          conv;

    assign div_wrap  = (div_cnt == DCW'(CLKDIV - 1));
    assign bit_last  = (bit_cnt == BCW'(FRAME - 1));
    assign zero_shot = !mode && (n_samples == '0);

    // Lowest enabled channel, and the next enabled one above ch_idx.
    always_comb begin
        first_ch = '0;
        nxt_ch   = '0;
        has_nxt  = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i]) first_ch = CW'(i);
            if (mask_q[i] && (i > int'(ch_idx))) begin
                nxt_ch  = CW'(i);
                has_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && (|ch_mask)) begin
                    go = 1'b1;
                    if (!zero_shot)
                        state_d = trig_en ? WAIT_TRIG : CONV;
                end
            end
            WAIT_TRIG: begin
                if (stop) begin
                    fin     = 1'b1;
                    state_d = IDLE;
                end else if (trig) begin
                    state_d = CONV;
                end
            end
            CONV: begin
                if (div_wrap && hi && bit_last) state_d = QUIET;
            end
            QUIET: begin
                if (div_wrap) state_d = STORE;
            end
            STORE: begin
                if (!has_nxt) state_d = CHECK;
            end
            CHECK: begin
                if ((!mode_q && (sample_cnt == n_q)) || stop_q || stop) begin
                    fin     = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = trig_en_q ? WAIT_TRIG : CONV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= 1'b0;
            trig_en_q  <= 1'b0;
            stop_q     <= 1'b0;
            n_q        <= '0;
            mask_q     <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            hi         <= 1'b1;
            ch_idx     <= '0;
            wr_ptr     <= '0;
            sh         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wrapped    <= 1'b0;
            sample_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (go) begin
                mode_q     <= mode;
                trig_en_q  <= trig_en;
                n_q        <= n_samples;
                mask_q     <= ch_mask;
                stop_q     <= 1'b0;
                wr_ptr     <= '0;
                sample_cnt <= '0;
                wrapped    <= 1'b0;
                busy       <= !zero_shot;
                done       <= zero_shot;
            end
            if (stop && (state_q inside {CONV, QUIET, STORE, CHECK}))
                stop_q <= 1'b1;
            if (fin) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
            // hi is forced high outside CONV so sclk never glitches
            // when the state changes.
            if (state_d != CONV)      hi <= 1'b1;
            else if (state_q != CONV) hi <= 1'b0;
            else if (div_wrap)        hi <= ~hi;
            if ((state_q == CONV) || (state_q == QUIET))
                div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            else
                div_cnt <= '0;
            if (state_q != CONV)
                bit_cnt <= '0;
            else if (div_wrap && hi)
                bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
            // Shift on the clk that ends the low half: sclk rises next.
            if ((state_q == CONV) && div_wrap && !hi) begin
                for (int i = 0; i < NCH; i++)
                    sh[i] <= {sh[i][DW-2:0], sdo[i]};
            end
            if (state_q == QUIET)
                ch_idx <= first_ch;
            else if ((state_q == STORE) && has_nxt)
                ch_idx <= nxt_ch;
            if (state_q == STORE) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (mode_q && (&wr_ptr)) wrapped <= 1'b1;
                if (!has_nxt) sample_cnt <= sample_cnt + 1'b1;
            end
        end
    end

    assign conv     = (state_q == CONV);
    assign cs_n     = ~(mask_q & {NCH{conv}});
    assign sclk     = ~(mask_q & {NCH{conv && !hi}});
    assign buf_we   = (state_q == STORE);
    assign buf_addr = wr_ptr;
    assign buf_din  = buf_we ? sh[ch_idx] : '0;

endmodule

// File: tb/tb_adc_multi_capture.sv
// tb_adc_multi_capture: vector table + hand sequences with a write scoreboard.
// Two serial ADC models feed fixed frames; writes are checked in order.
module tb_adc_multi_capture;

    localparam int NCH = 2, DW = 12, FRAME = 16, CLKDIV = 2, AW = 4;

    logic clk = 0, rst_n = 0, start = 0, stop = 0;
    logic mode = 0, trig_en = 0, trig = 0;
    logic [AW-1:0] n_samples = '0;
    logic [NCH-1:0] ch_mask = '0;
    logic sdo0 = 0, sdo1 = 0;
    logic [NCH-1:0] sdo;
    logic [NCH-1:0] cs_n, sclk;
    logic buf_we, busy, done, wrapped;
    logic [AW-1:0] buf_addr, sample_cnt;
    logic [DW-1:0] buf_din;

    assign sdo = {sdo1, sdo0};
    always #5 clk = ~clk;

    adc_multi_capture #(.NCH(NCH), .DW(DW), .FRAME(FRAME),
                        .CLKDIV(CLKDIV), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .mode(mode), .trig_en(trig_en), .trig(trig),
        .n_samples(n_samples), .ch_mask(ch_mask), .sdo(sdo),
        .cs_n(cs_n), .sclk(sclk), .buf_we(buf_we),
        .buf_addr(buf_addr), .buf_din(buf_din), .busy(busy),
        .done(done), .wrapped(wrapped), .sample_cnt(sample_cnt)
    );

    logic [15:0] w0 = 16'h5A5A, w1 = 16'h93C3;
    int c0 = 0, c1 = 0;

    // ADC models: next bit MSB-first on each falling sclk.
    always @(posedge cs_n[0] or negedge sclk[0]) begin
        if (cs_n[0]) c0 = 0;
        else begin
            sdo0 = w0[4'(15 - c0)];
            c0++;
        end
    end
    always @(posedge cs_n[1] or negedge sclk[1]) begin
        if (cs_n[1]) c1 = 0;
        else begin
            sdo1 = w1[4'(15 - c1)];
            c1++;
        end
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic [1:0] mask;
        int n, cs0, cs1, sk0, sk1, wr;
    } vec_t;
    vec_t vt[3];

    int checks = 0, errors = 0;
    int nwr = 0, ncs0 = 0, ncs1 = 0, nsk0 = 0, nsk1 = 0, ndone = 0;
    int b_wr, b_cs0, b_cs1, b_sk0, b_sk1, b_done;

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (buf_we) begin
            nwr++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         buf_addr, buf_din);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(buf_addr), 32'(e.addr));
                chk("wr_data", 32'(buf_din), 32'(e.data));
            end
        end
        if (!cs_n[0]) ncs0++;
        if (!cs_n[1]) ncs1++;
        if (!sclk[0]) nsk0++;
        if (!sclk[1]) nsk1++;
        if (done) ndone++;
    endtask

    function automatic void push_frames(input logic [1:0] m,
                                        input int frames);
        wr_t e;
        int a = 0;
        for (int f = 0; f < frames; f++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (m[ch]) begin
                    e.addr = AW'(a);
                    e.data = ch ? w1[11:0] : w0[11:0];
                    sb.push_back(e);
                    a++;
                end
            end
        end
    endfunction

    task automatic snap();
        b_wr = nwr; b_cs0 = ncs0; b_cs1 = ncs1;
        b_sk0 = nsk0; b_sk1 = nsk1; b_done = ndone;
    endtask

    task automatic run_start(input logic [1:0] m, input logic md,
                             input logic te, input int n);
        ch_mask = m; mode = md; trig_en = te; n_samples = AW'(n);
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 1);
    endtask

    task automatic wait_cnt(input int target, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (sample_cnt == AW'(target)) begin
                seen = 1;
                break;
            end
        end
        chk("cnt_reached", 32'(seen), 1);
    endtask

    initial begin
        vt[0] = '{2'b11, 3, 192, 192, 96, 96, 6};
        vt[1] = '{2'b10, 2, 0, 128, 0, 64, 2};
        vt[2] = '{2'b01, 1, 64, 0, 32, 0, 1};

        repeat (3) tick();
        chk("rst_cs_n", 32'(cs_n), 3);
        chk("rst_sclk", 32'(sclk), 3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_we", 32'(buf_we), 0);
        chk("rst_cnt", 32'(sample_cnt), 0);
        rst_n = 1;
        tick();
        chk("idle_done", 32'(done), 0);

        for (int v = 0; v < 3; v++) begin
            snap();
            push_frames(vt[v].mask, vt[v].n);
            run_start(vt[v].mask, 0, 0, vt[v].n);
            chk("v_cs_low_start", 32'(cs_n), 32'(~vt[v].mask & 2'b11));
            wait_done(1000);
            chk("v_busy", 32'(busy), 0);
            chk("v_cnt", 32'(sample_cnt), 32'(vt[v].n));
            chk("v_writes", 32'(nwr - b_wr), 32'(vt[v].wr));
            chk("v_cs0", 32'(ncs0 - b_cs0), 32'(vt[v].cs0));
            chk("v_cs1", 32'(ncs1 - b_cs1), 32'(vt[v].cs1));
            chk("v_sk0", 32'(nsk0 - b_sk0), 32'(vt[v].sk0));
            chk("v_sk1", 32'(nsk1 - b_sk1), 32'(vt[v].sk1));
            chk("v_sb_empty", 32'(sb.size()), 0);
            tick();
            chk("v_done_pulse", 32'(ndone - b_done), 1);
        end

        // Zero-length single shot and empty mask.
        snap();
        run_start(2'b11, 0, 0, 0);
        chk("zero_done", 32'(done), 1);
        chk("zero_busy", 32'(busy), 0);
        tick();
        chk("zero_done_end", 32'(done), 0);
        run_start(2'b00, 0, 0, 3);
        chk("mask0_busy", 32'(busy), 0);
        repeat (5) tick();
        chk("mask0_busy2", 32'(busy), 0);
        chk("zero_no_cs", 32'(ncs0 - b_cs0), 0);
        chk("zero_no_wr", 32'(nwr - b_wr), 0);

        // Per-frame trigger.
        snap();
        push_frames(2'b11, 2);
        run_start(2'b11, 0, 1, 2);
        chk("trig_wait_cs", 32'(cs_n), 3);
        repeat (50) tick();
        chk("trig_no_cs", 32'(ncs0 - b_cs0), 0);
        chk("trig_busy", 32'(busy), 1);
        trig = 1; tick(); trig = 0;
        chk("trig_cs_low", 32'(cs_n), 0);
        repeat (20) tick();
        trig = 1; tick(); trig = 0;
        wait_cnt(1, 200);
        repeat (60) tick();
        chk("trig_one_frame", 32'(ncs0 - b_cs0), 64);
        trig = 1; tick(); trig = 0;
        wait_done(200);
        chk("trig_cs_total", 32'(ncs0 - b_cs0), 128);
        chk("trig_writes", 32'(nwr - b_wr), 4);
        chk("trig_cnt", 32'(sample_cnt), 2);

        // Stop while waiting for a trigger.
        snap();
        run_start(2'b11, 0, 1, 2);
        stop = 1; tick(); stop = 0;
        chk("wt_stop_done", 32'(done), 1);
        chk("wt_stop_busy", 32'(busy), 0);
        chk("wt_stop_no_wr", 32'(nwr - b_wr), 0);

        // Continuous ring with wrap, then stop mid-frame.
        snap();
        push_frames(2'b11, 9);
        run_start(2'b11, 1, 0, 0);
        wait_cnt(7, 2000);
        chk("ring_not_wrapped", 32'(wrapped), 0);
        wait_cnt(8, 200);
        chk("ring_wrapped", 32'(wrapped), 1);
        chk("ring_addr0", 32'(buf_addr), 0);
        repeat (10) tick();
        stop = 1; tick(); stop = 0;
        wait_done(200);
        chk("ring_cnt", 32'(sample_cnt), 9);
        chk("ring_writes", 32'(nwr - b_wr), 18);
        chk("ring_sticky", 32'(wrapped), 1);

        // Restart clears wrapped; start while busy is ignored.
        snap();
        push_frames(2'b11, 1);
        run_start(2'b11, 0, 0, 1);
        chk("restart_wrap_clr", 32'(wrapped), 0);
        chk("restart_busy", 32'(busy), 1);
        repeat (5) tick();
        run_start(2'b01, 0, 0, 5);
        wait_done(200);
        chk("busy_start_cnt", 32'(sample_cnt), 1);
        chk("busy_start_wr", 32'(nwr - b_wr), 2);

        // Asynchronous reset mid-frame.
        snap();
        run_start(2'b11, 0, 0, 3);
        repeat (30) tick();
        #2 rst_n = 0;
        #1;
        chk("arst_cs_n", 32'(cs_n), 3);
        chk("arst_sclk", 32'(sclk), 3);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_we", 32'(buf_we), 0);
        chk("arst_addr", 32'(buf_addr), 0);
        chk("arst_din", 32'(buf_din), 0);
        chk("arst_cnt", 32'(sample_cnt), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_wrapped", 32'(wrapped), 0);
        tick();
        rst_n = 1;
        tick();
        chk("arst_no_wr", 32'(nwr - b_wr), 0);
        snap();
        push_frames(2'b11, 1);
        run_start(2'b11, 0, 0, 1);
        wait_done(200);
        chk("arst_re_wr", 32'(nwr - b_wr), 2);
        chk("arst_re_cnt", 32'(sample_cnt), 1);
        chk("final_sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
